// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: pipelined bitwise logic unit with eight operations on A/B.
// There is valid/ready flow control with backpressure and an occupancy count.
// PIPE_DEPTH register stages; latency equals PIPE_DEPTH with out_ready held high.
// Optional feature macro: BLP_ZERO_FLAG_EN. When it is defined, a zero flag is
// carried alongside the data. When it is undefined, out_zero is tied low.
module bitwise_logic_pipe #(
  parameter int WIDTH      = 32,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [2:0]                      in_op,
  input  logic [WIDTH-1:0]                in_a,
  input  logic [WIDTH-1:0]                in_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_zero,
  output logic [$clog2(PIPE_DEPTH+1)-1:0] occupancy
);

  localparam int LAST  = PIPE_DEPTH - 1;
  localparam int OCC_W = $clog2(PIPE_DEPTH + 1);

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("bitwise_logic_pipe: PIPE_DEPTH must be within 1..4");
  end

  // Operation table; NOT and PASS ignore operand B.
  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = ~a;
      3'b001:  r = a & b;
      3'b010:  r = a | b;
      3'b011:  r = a ^ b;
      3'b100:  r = ~(a & b);
      3'b101:  r = ~(a | b);
      3'b110:  r = ~(a ^ b);
      default: r = a;
    endcase
    return r;
  endfunction

  logic [PIPE_DEPTH-1:0]            vld_q;
  logic [PIPE_DEPTH-1:0]            vld_d;
  logic [PIPE_DEPTH-1:0]            load;
  logic [PIPE_DEPTH-1:0]            src_vld;
  logic [PIPE_DEPTH-1:0][WIDTH-1:0] data_q;
  logic [PIPE_DEPTH-1:0][WIDTH-1:0] src_data;
  logic [OCC_W-1:0]                 occ_q;
  logic [OCC_W-1:0]                 occ_d;
  logic [WIDTH-1:0]                 op_res;
  logic                             tail_full;

  assign op_res = logic_op(in_op, in_a, in_b);

  // Stage 0 takes the fresh result; every later stage takes its predecessor.
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_vld[k]  = in_valid;
      assign src_data[k] = op_res;
    end else begin : g_body
      assign src_vld[k]  = vld_q[k-1];
      assign src_data[k] = data_q[k-1];
    end
  end

  // A stage may load if it or any later stage is empty, or if the consumer takes the result.
  always_comb begin
    tail_full = 1'b1;
    load      = '0;
    for (int k = LAST; k >= 0; k--) begin
      tail_full = tail_full & vld_q[k];
      load[k]   = out_ready | ~tail_full;
    end
  end

  // Next-state stage valids and the matching occupancy count.
  always_comb begin
    vld_d = vld_q;
    occ_d = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (load[k]) vld_d[k] = src_vld[k];
      occ_d = occ_d + OCC_W'(vld_d[k]);
    end
  end

  // Stage registers. Data only moves when a valid op moves in, so a stalled output is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      data_q <= '0;
      occ_q  <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (load[k] && src_vld[k]) data_q[k] <= src_data[k];
      end
    end
  end

`ifdef BLP_ZERO_FLAG_EN
  logic [PIPE_DEPTH-1:0] zero_q;
  logic [PIPE_DEPTH-1:0] src_zero;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_zsrc
    if (k == 0) begin : g_head
      assign src_zero[k] = ~|op_res;
    end else begin : g_body
      assign src_zero[k] = zero_q[k-1];
    end
  end

  // Zero flag follows its data word through the stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zero_q <= '0;
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (load[k] && src_vld[k]) zero_q[k] <= src_zero[k];
      end
    end
  end

  assign out_zero = zero_q[LAST];
`else
  assign out_zero = 1'b0;
`endif

  assign in_ready  = load[0];
  assign out_valid = vld_q[LAST];
  assign out_data  = data_q[LAST];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Testbench for bitwise_logic_pipe (WIDTH=32, PIPE_DEPTH=2).
// It uses directed steps plus random traffic, checked against a queue-based reference model.
module tb_bitwise_logic_pipe;
  localparam int W  = 32;
  localparam int D  = 2;
  localparam int OW = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic [OW-1:0] occupancy;

  bitwise_logic_pipe #(.WIDTH(W), .PIPE_DEPTH(D)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  int           n_assert = 0;
  int           n_fail   = 0;
  int           n_out    = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_zq[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  // Reference: the operation table written out directly.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic logic ref_zero(input logic [W-1:0] r);
`ifdef BLP_ZERO_FLAG_EN
    return (r == '0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven.
  // Checks the cycle, updates the model and advances one clock.
  task automatic step();
    #1;
    chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
    chk("in_ready", 64'(in_ready), 64'((exp_q.size() < D) || out_ready));
    if (prev_stall) chk("stall_hold", 64'(out_data), 64'(prev_data));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(1), 64'(0));
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        chk("out_zero", 64'(out_zero), 64'(exp_zq.pop_front()));
        n_out++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_op(in_op, in_a, in_b));
      exp_zq.push_back(ref_zero(ref_op(in_op, in_a, in_b)));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  int           lat;
  int           start;
  logic [W-1:0] ra;

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, '0, '0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_zero", 64'(out_zero), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));

    // Latency of a single NOT op
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 32'h0000FFFF, $urandom);
    step();
    drive(1'b0, 3'd0, '0, '0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("latency", 64'(lat), 64'(D));
    chk("not_data", 64'(out_data), 64'(32'hFFFF0000));
    chk("not_zero", 64'(out_zero), 64'(0));
    step();

    // All eight ops back to back; the outputs must fill consecutive cycles.
    start = n_out;
    for (int op = 0; op < 8; op++) begin
      drive(1'b1, 3'(op), 32'hF0F0F0F0, 32'hFF00FF00);
      step();
    end
    drive(1'b0, 3'd0, '0, '0);
    repeat (D) step();
    chk("sweep_count", 64'(n_out - start), 64'(8));
    chk("sweep_drained", 64'(exp_q.size()), 64'(0));

    // XOR of equal operands gives zero
    drive(1'b1, 3'd3, 32'h12345678, 32'h12345678);
    step();
    drive(1'b0, 3'd0, '0, '0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("xor_latency", 64'(lat), 64'(D));
    chk("xor_data", 64'(out_data), 64'(0));
`ifdef BLP_ZERO_FLAG_EN
    chk("xor_zero", 64'(out_zero), 64'(1));
`else
    chk("xor_zero", 64'(out_zero), 64'(0));
`endif
    step();

    // Backpressure: fill, stall the third op, then release.
    out_ready = 1'b0;
    drive(1'b1, 3'd1, $urandom, $urandom);
    step();
    drive(1'b1, 3'd2, $urandom, $urandom);
    step();
    drive(1'b1, 3'd6, $urandom, $urandom);
    chk("bp_occupancy", 64'(occupancy), 64'(D));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    repeat (3) step();
    start     = n_out;
    out_ready = 1'b1;
    step();
    drive(1'b0, 3'd0, '0, '0);
    repeat (2) step();
    chk("bp_release_count", 64'(n_out - start), 64'(3));
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra,
            ($urandom_range(0, 7) == 0) ? ra : W'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, 3'd0, '0, '0);
    out_ready = 1'b1;
    repeat (D + 1) step();
    chk("rand_drained", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset while the pipe is full
    out_ready = 1'b0;
    drive(1'b1, 3'd0, $urandom, $urandom);
    step();
    drive(1'b1, 3'd7, $urandom, $urandom);
    step();
    drive(1'b0, 3'd0, '0, '0);
    chk("pre_rst_occupancy", 64'(occupancy), 64'(D));
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_occupancy", 64'(occupancy), 64'(0));
    chk("async_rst_out_data", 64'(out_data), 64'(0));
    exp_q.delete();
    exp_zq.delete();
    prev_stall = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    start     = n_out;
    repeat (4) step();
    chk("no_stale_out", 64'(n_out - start), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
